control_fsm: RTL and testbench

Instruction-cycle sequencer of the processor core: it generates the 4-bit `state` code that the control-signal unit decodes into register-file, ULA, PC and ROM strobes. It walks fetch → decode → execute → write-back and waits on ROM and multi-cycle ULA handshakes. It latches the instruction opcode that drives the ULA operation select, and counts retired instructions.

---
 rtl/control_fsm_pkg.sv | 28 ++
 rtl/control_fsm.sv | 144 ++++++++++++++
 tb/tb_control_fsm.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/control_fsm_pkg.sv
// -----------------------------------------------------------------------------
// control_fsm_pkg
// Shared definitions for the instruction-cycle sequencer and the
// control-signal unit that decodes its state code.
//   STATE_W          : width of the state code (4)
//   state_e          : state codes S_RESET..S_STEP_WAIT (9..15 illegal)
//   OP_NOP / OP_HALT : opcodes the sequencer handles without the ULA
// -----------------------------------------------------------------------------
package control_fsm_pkg;

    localparam int unsigned STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        S_RESET      = 4'd0,
        S_FETCH      = 4'd1,
        S_FETCH_WAIT = 4'd2,
        S_DECODE     = 4'd3,
        S_ULA_OP     = 4'd4,
        S_ULA_WAIT   = 4'd5,
        S_STORE_RES  = 4'd6,
        S_HALT       = 4'd7,
        S_STEP_WAIT  = 4'd8
    } state_e;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_HALT = 4'hF;

endpackage

// File: rtl/control_fsm.sv
// -----------------------------------------------------------------------------
// control_fsm
// Instruction-cycle sequencer: fetch -> decode -> execute -> write-back.
// Produces the 4-bit state code for the control-signal unit, latches the
// opcode that selects the ULA operation and counts retired instructions.
//
// Optional feature macro: CONTROL_FSM_STEP_MODE_EN
//   defined   : `step` port exists; S_STORE_RES -> S_STEP_WAIT, step=1 -> S_FETCH
//   undefined : no `step` port; code 8 is illegal like 9..15
//
// Parameters
//   CNT_W         : width of the retired-instruction counter (wraps, no saturation)
//   MC_OPCODE_MIN : opcodes MC_OPCODE_MIN..4'hE are multi-cycle ULA ops
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   start        in   leave S_RESET / S_HALT
//   opcode       in   opcode of the fetched instruction, sampled in S_DECODE
//   rom_ready    in   ROM data valid, sampled in S_FETCH_WAIT
//   ula_done     in   multi-cycle ULA result valid, sampled in S_ULA_WAIT
//   step         in   single-step advance (step mode only)
//   state        out  current state code (also the FSM debug view)
//   opcode_q     out  latched opcode
//   instr_count  out  retired-instruction count
//   halted       out  high in S_HALT
//   busy         out  high except in S_RESET, S_HALT, S_STEP_WAIT
//
// Handshake: rom_ready, ula_done and step are level "valid" signals from the
// responder. The sequencer is implicitly ready only while sitting in the one
// wait state that samples each of them; a transfer happens on the rising edge
// where that state and the valid are both high. Outside that state the valid
// is ignored, so an early pulse is lost rather than remembered.
// -----------------------------------------------------------------------------
module control_fsm
    import control_fsm_pkg::*;
#(
    parameter int unsigned        CNT_W         = 16,
    parameter logic [STATE_W-1:0] MC_OPCODE_MIN = 4'h8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [3:0]         opcode,
    input  logic               rom_ready,
    input  logic               ula_done,
`ifdef CONTROL_FSM_STEP_MODE_EN
    input  logic               step,
`endif
    output logic [STATE_W-1:0] state,
    output logic [3:0]         opcode_q,
    output logic [CNT_W-1:0]   instr_count,
    output logic               halted,
    output logic               busy
);

    state_e             state_q, state_d;
    logic [3:0]         op_q, op_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               retire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RESET;
            op_q    <= OP_NOP;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        retire  = 1'b0;
        case (state_q)
            S_RESET: begin
                if (start) state_d = S_FETCH;
            end
            // Exactly one cycle, so the PC/ROM strobes fire once per instruction.
            S_FETCH: begin
                state_d = S_FETCH_WAIT;
            end
            S_FETCH_WAIT: begin
                if (rom_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                op_d = opcode;
                if (opcode == OP_HALT) begin
                    state_d = S_HALT;
                    retire  = 1'b1;
                end else if (opcode == OP_NOP) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end else begin
                    state_d = S_ULA_OP;
                end
            end
            // HALT never reaches here, but the explicit exclusion keeps the
            // multi-cycle range MC_OPCODE_MIN..4'hE regardless of how the
            // range test is written.
            S_ULA_OP: begin
                if ((op_q >= MC_OPCODE_MIN) && (op_q != OP_HALT))
                    state_d = S_ULA_WAIT;
                else
                    state_d = S_STORE_RES;
            end
            S_ULA_WAIT: begin
                if (ula_done) state_d = S_STORE_RES;
            end
            S_STORE_RES: begin
                retire  = 1'b1;
`ifdef CONTROL_FSM_STEP_MODE_EN
                state_d = S_STEP_WAIT;
`else
                state_d = S_FETCH;
`endif
            end
            S_HALT: begin
                if (start) state_d = S_FETCH;
            end
`ifdef CONTROL_FSM_STEP_MODE_EN
            S_STEP_WAIT: begin
                if (step) state_d = S_FETCH;
            end
`endif
            // Illegal codes (and S_STEP_WAIT when step mode is off) recover.
            default: begin
                state_d = S_RESET;
            end
        endcase
    end

    assign count_d = retire ? count_q + CNT_W'(1) : count_q;

    assign state       = state_q;
    assign opcode_q    = op_q;
    assign instr_count = count_q;
    assign halted      = (state_q == S_HALT);
    assign busy        = !((state_q == S_RESET) || (state_q == S_HALT) ||
                           (state_q == S_STEP_WAIT));

endmodule

// File: tb/tb_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_control_fsm
// Directed bench for control_fsm (CNT_W=4 so the counter wrap is reachable).
// Driver tasks apply inputs on the falling edge and push the expected
// post-edge snapshot {state, opcode_q, instr_count, halted, busy}; a monitor
// process pops and compares one entry just after every rising edge.
// -----------------------------------------------------------------------------
module tb_control_fsm;

    localparam int CW = 4;
    localparam int W  = 4 + 4 + CW + 2;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [3:0]    opcode;
    logic          rom_ready;
    logic          ula_done;
    logic          step;
    logic [3:0]    state;
    logic [3:0]    opcode_q;
    logic [CW-1:0] instr_count;
    logic          halted;
    logic          busy;

    logic [W-1:0]  exp_q[$];
    logic [3:0]    m_op;
    logic [CW-1:0] m_cnt;
    int            n_checks;
    int            n_fail;

    control_fsm #(.CNT_W(CW), .MC_OPCODE_MIN(4'h8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .opcode      (opcode),
        .rom_ready   (rom_ready),
        .ula_done    (ula_done),
`ifdef CONTROL_FSM_STEP_MODE_EN
        .step        (step),
`endif
        .state       (state),
        .opcode_q    (opcode_q),
        .instr_count (instr_count),
        .halted      (halted),
        .busy        (busy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    function automatic logic [W-1:0] pack(input logic [3:0] s, input logic [3:0] o,
                                          input logic [CW-1:0] c);
        logic h, b;
        h = (s == 4'd7);
        b = !((s == 4'd0) || (s == 4'd7) || (s == 4'd8));
        return {s, o, c, h, b};
    endfunction

    function automatic logic [W-1:0] actual();
        return {state, opcode_q, instr_count, halted, busy};
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got state=%0d op=%h cnt=%0d halted=%b busy=%b, expected state=%0d op=%h cnt=%0d halted=%b busy=%b",
                     name, act[W-1 -: 4], act[W-5 -: 4], act[CW+1:2], act[1], act[0],
                     exp[W-1 -: 4], exp[W-5 -: 4], exp[CW+1:2], exp[1], exp[0]);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [W-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("state_trace", actual(), e);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // One cycle: apply inputs, expect state es afterwards with the model op/count.
    task automatic drive(input logic st, input logic rr, input logic ud, input logic stp,
                         input logic [3:0] op, input logic [3:0] es);
        @(negedge clk);
        start     = st;
        rom_ready = rr;
        ula_done  = ud;
        step      = stp;
        opcode    = op;
        exp_q.push_back(pack(es, m_op, m_cnt));
    endtask

    // From S_FETCH to S_DECODE. Opcode is driven to HALT outside decode and
    // ula_done high, both of which must be ignored.
    task automatic fetch_to_decode(input int stall);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 4'd2);
        for (int i = 0; i < stall; i++) drive(1'b0, 1'b0, 1'b1, 1'b1, 4'hF, 4'd2);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 4'd3);
    endtask

    task automatic decode(input logic [3:0] op);
        m_op = op;
        if (op == 4'hF) begin
            m_cnt = m_cnt + 1'b1;
            drive(1'b0, 1'b1, 1'b0, 1'b0, op, 4'd7);
        end else if (op == 4'h0) begin
            m_cnt = m_cnt + 1'b1;
            drive(1'b0, 1'b1, 1'b0, 1'b0, op, 4'd1);
        end else begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, op, 4'd4);
        end
    endtask

    task automatic store_tail();
        m_cnt = m_cnt + 1'b1;
`ifdef CONTROL_FSM_STEP_MODE_EN
        drive(1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 4'd8);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 4'd8);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 4'd1);
`else
        drive(1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 4'd1);
`endif
    endtask

    // Full instruction from S_FETCH back to S_FETCH (or S_HALT for 4'hF).
    task automatic run_instr(input logic [3:0] op, input int stall, input int wait_n);
        logic mc;
        fetch_to_decode(stall);
        decode(op);
        if (op != 4'hF && op != 4'h0) begin
            mc = (op >= 4'h8);
            // ula_done pulse while in S_ULA_OP must not skip S_ULA_WAIT
            drive(1'b0, 1'b1, 1'b1, 1'b0, 4'hF, mc ? 4'd5 : 4'd6);
            if (mc) begin
                for (int i = 0; i < wait_n; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 4'hF, 4'd5);
                drive(1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 4'd6);
            end
            store_tail();
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        n_checks  = 0;
        n_fail    = 0;
        m_op      = 4'h0;
        m_cnt     = '0;
        rst_n     = 1'b0;
        start     = 1'b0;
        opcode    = 4'h0;
        rom_ready = 1'b0;
        ula_done  = 1'b0;
        step      = 1'b0;

        #12;
        check("reset_values", actual(), pack(4'd0, 4'h0, '0));
        @(negedge clk);
        rst_n = 1'b1;

        // Nothing happens without start, even with handshakes high.
        drive(1'b0, 1'b1, 1'b1, 1'b1, 4'h3, 4'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h3, 4'd1);

        run_instr(4'h3, 0, 0);   // single-cycle ALU, 5 cycles
        run_instr(4'h3, 4, 0);   // ROM stall in FETCH_WAIT
        run_instr(4'h9, 2, 2);   // multi-cycle, ula_done on 3rd WAIT cycle
        run_instr(4'h8, 0, 0);   // lowest multi-cycle opcode
        run_instr(4'h7, 0, 0);   // highest single-cycle opcode
        run_instr(4'hE, 1, 1);   // highest multi-cycle opcode

        // HALT: retired, idle, inputs ignored until start.
        run_instr(4'hF, 0, 0);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 4'd7);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 4'd7);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 4'd1);

        // 16 NOPs: 4-bit counter passes 15 -> 0 and returns to its start value.
        for (int i = 0; i < 16; i++) run_instr(4'h0, 0, 0);

        // Asynchronous reset while waiting on the ULA.
        fetch_to_decode(0);
        decode(4'h9);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 4'hF, 4'd5);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        m_op  = 4'h0;
        m_cnt = '0;
        check("async_reset", actual(), pack(4'd0, 4'h0, '0));
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 1'b1, 4'h9, 4'd0);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 4'h9, 4'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h9, 4'd1);
        run_instr(4'h5, 0, 0);

        // Drain: every pushed expectation must have been compared.
        @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound in case the sequence stalls.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
